// File: rtl/cla_pkg.sv
// Shared constants and parameter legality check for the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam int unsigned CLA_GROUP_BITS = 4;

  // True when the width/stage split can be built from whole lookahead groups.
  function automatic bit cla_params_legal(input int unsigned width, input int unsigned stage_bits);
    return (width != 0) && (stage_bits != 0) &&
           ((stage_bits % CLA_GROUP_BITS) == 0) && ((width % stage_bits) == 0);
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead group; c3 is the carry into bit 3 for overflow detection.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;

  // Propagate/generate terms and flattened lookahead carries.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c1   = g[0] | (p[0] & cin);
    c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one STAGE_BITS slice resolved per stage,
// unconsumed operand slices and finished sum slices travel with the beat.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGE_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf
);

  localparam int unsigned NSTAGE = WIDTH / STAGE_BITS;
  localparam int unsigned NGRP   = STAGE_BITS / CLA_GROUP_BITS;

  if (!cla_params_legal(WIDTH, STAGE_BITS)) begin : g_param_check
    $error("cla_pipe_addsub: WIDTH must be a multiple of STAGE_BITS, STAGE_BITS a multiple of 4");
  end

  logic             stall_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             c0_c;

  // Whole pipeline freezes while the result sits unaccepted.
  assign stall_c  = out_valid & ~out_ready;
  assign in_ready = ~stall_c;

  // Subtraction is A + ~B + 1; carry-in is forced in that mode.
  always_comb begin
    b_eff_c = in_sub ? ~in_b : in_b;
    c0_c    = in_sub | in_cin;
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned LO  = k * STAGE_BITS;
    localparam int unsigned REM = WIDTH - (k + 1) * STAGE_BITS;

    logic [STAGE_BITS-1:0]    op_a;
    logic [STAGE_BITS-1:0]    op_b;
    logic [STAGE_BITS-1:0]    s_slice;
    logic                     cin;
    logic                     v_in;
    logic [NGRP:0]            gc;
    logic [NGRP-1:0]          grp_c3;
    logic                     c3_unused;
    logic                     valid_d;
    logic                     valid_q;
    logic                     carry_d;
    logic                     carry_q;
    logic [LO+STAGE_BITS-1:0] sum_d;
    logic [LO+STAGE_BITS-1:0] sum_q;

    if (k == 0) begin : g_src
      assign op_a = in_a[STAGE_BITS-1:0];
      assign op_b = b_eff_c[STAGE_BITS-1:0];
      assign cin  = c0_c;
      assign v_in = in_valid;

      // First slice of the result.
      always_comb begin
        sum_d = s_slice;
      end
    end else begin : g_src
      assign op_a = g_stage[k-1].g_fwd.a_q[STAGE_BITS-1:0];
      assign op_b = g_stage[k-1].g_fwd.b_q[STAGE_BITS-1:0];
      assign cin  = g_stage[k-1].carry_q;
      assign v_in = g_stage[k-1].valid_q;

      // Append this slice above the already-resolved lower slices.
      always_comb begin
        sum_d = {s_slice, g_stage[k-1].sum_q};
      end
    end

    assign gc[0] = cin;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      cla4_slice u_cla4 (
        .a    (op_a[g*CLA_GROUP_BITS +: CLA_GROUP_BITS]),
        .b    (op_b[g*CLA_GROUP_BITS +: CLA_GROUP_BITS]),
        .cin  (gc[g]),
        .s    (s_slice[g*CLA_GROUP_BITS +: CLA_GROUP_BITS]),
        .cout (gc[g+1]),
        .c3   (grp_c3[g])
      );
    end

    // Only the top group's c3 of the last stage matters.
    assign c3_unused = ^grp_c3;

    // Stage valid and carry-out.
    always_comb begin
      valid_d = v_in;
      carry_d = gc[NGRP];
    end

    // Stage valid/carry/sum registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall_c) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (REM > 0) begin : g_fwd
      logic [REM-1:0] a_d;
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_d;
      logic [REM-1:0] b_q;

      if (k == 0) begin : g_in
        // Operand slices not yet consumed.
        always_comb begin
          a_d = in_a[WIDTH-1:STAGE_BITS];
          b_d = b_eff_c[WIDTH-1:STAGE_BITS];
        end
      end else begin : g_in
        // Drop the slice consumed by this stage.
        always_comb begin
          a_d = g_stage[k-1].g_fwd.a_q[REM+STAGE_BITS-1:STAGE_BITS];
          b_d = g_stage[k-1].g_fwd.b_q[REM+STAGE_BITS-1:STAGE_BITS];
        end
      end

      // Remaining operand registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall_c) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == NSTAGE - 1) begin : g_last
      logic ovf_d;
      logic ovf_q;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_comb begin
        ovf_d = grp_c3[NGRP-1] ^ gc[NGRP];
      end

      // Overflow flag registered alongside the final sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!stall_c) begin
          ovf_q <= ovf_d;
        end
      end

      assign out_valid = valid_q;
      assign out_sum   = {carry_q, sum_q};
      assign out_ovf   = ovf_q;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub (16-bit, 4-bit stages): directed cases plus random beats
// against an arithmetic reference model and an in-order scoreboard.
module tb_cla_pipe_addsub;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned STAGE_BITS = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              in_cin;
  logic              in_sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH:0]    out_sum;
  logic              out_ovf;

  cla_pipe_addsub #(.WIDTH(WIDTH), .STAGE_BITS(STAGE_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  int unsigned   n_popped = 0;
  logic [17:0]   exp_q[$];
  logic          acc_last;
  logic          pre_in_ready;
  logic          pre_out_valid;
  logic [16:0]   pre_out_sum;
  logic          prev_stall = 1'b0;
  logic [16:0]   prev_sum;
  logic          prev_ovf;

  // Reference: {ovf, carry/no-borrow, 16-bit result} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    int unsigned ua;
    int unsigned ub;
    int unsigned raw;
    int          sr;
    logic        ovf;
    ua = a;
    ub = b;
    if (sub) begin
      raw = ua + 32'd65536 - ub;
      sr  = int'($signed(a)) - int'($signed(b));
    end else begin
      raw = ua + ub + 32'(cin);
      sr  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    ovf = (sr > 32767) || (sr < -32768);
    return {ovf, 17'(raw)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard the handshakes seen before the edge, then advance past it.
  task automatic tick();
    logic [17:0] e;
    #1;
    pre_in_ready  = in_ready;
    pre_out_valid = out_valid;
    pre_out_sum   = out_sum;
    acc_last      = 1'b0;
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_sum", 32'(out_sum), 32'(prev_sum));
        chk("hold_ovf", 32'(out_ovf), 32'(prev_ovf));
      end
      if (out_valid && out_ready) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_errors++;
          $error("FAIL sb_spurious: observed=out_valid expected=no_pending_beat sum=%0h", out_sum);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_popped++;
          chk("sb_sum", 32'(out_sum), 32'(e[16:0]));
          chk("sb_ovf", 32'(out_ovf), 32'(e[17]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_a, in_b, in_cin, in_sub));
        acc_last = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_ovf   = out_ovf;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    if (rst) exp_q.delete();
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
  endtask

  // Single beat with exact latency and constant expected result.
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [16:0] es, input logic eo);
    drive(a, b, cin, sub);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_early"}, 32'(out_valid), 32'd0);
    end
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(out_sum), 32'(es));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;
    int          stall_left;
    logic        stall_done;
    logic [16:0] held;
    int unsigned sent;
    logic [15:0] ra [6];
    logic [15:0] rb [6];
    logic        rc [6];
    logic        rs [6];

    rst       = 1'b1;
    out_ready = 1'b1;
    idle();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_ovf", 32'(out_ovf), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
    end
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Directed add/sub corners.
    single("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h1_0000, 1'b0);
    single("add_7fff_c", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 17'h0_8000, 1'b1);
    single("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0_FFFE, 1'b0);
    single("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h1_7FFF, 1'b1);
    single("sub_5_7_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE, 1'b0);
    single("sub_8000_1_cin", 16'h8000, 16'h0001, 1'b1, 1'b1, 17'h1_7FFF, 1'b1);

    // Six back-to-back random beats with a three-cycle output stall.
    for (int i = 0; i < 6; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    start      = n_popped;
    sent       = 0;
    stall_left = 0;
    stall_done = 1'b0;
    held       = '0;
    for (int cyc = 0; cyc < 60 && (n_popped - start) < 6; cyc++) begin
      if (sent < 6) drive(ra[sent], rb[sent], rc[sent], rs[sent]);
      else idle();
      if (!stall_done && out_valid) begin
        stall_left = 3;
        stall_done = 1'b1;
        held       = out_sum;
      end
      out_ready = (stall_left == 0);
      tick();
      if (stall_left > 0) begin
        chk("stall_in_ready", 32'(pre_in_ready), 32'd0);
        chk("stall_out_sum", 32'(pre_out_sum), 32'(held));
        stall_left--;
      end
      if (acc_last) sent++;
    end
    idle();
    out_ready = 1'b1;
    chk("stream_stalled", 32'(stall_done), 32'd1);
    chk("stream_count", n_popped - start, 32'd6);
    chk("stream_sent", sent, 32'd6);

    // Alternating valid/bubble input.
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 2) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else idle();
      tick();
      chk("alt_out_valid", 32'(pre_out_valid), (i == 4 || i == 6) ? 32'd1 : 32'd0);
    end
    idle();

    // Random traffic with random backpressure, then drain.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) != 0) drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else idle();
      out_ready = ($urandom_range(3, 0) != 0);
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Reset while two beats are in flight.
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    tick();
    drive(16'h3333, 16'h4444, 1'b0, 1'b1);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
    end
    single("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 17'h0_2345, 1'b0);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups with carry-in.
- Each pipeline stage resolves STAGE_BITS of the result; the inter-stage carry and the not-yet-consumed operand slices are registered.
- Sits on the accurate-path datapath feeding the approximate-logarithmic multiplier blocks; valid/ready on both sides.

Parameters:
- WIDTH, 16, operand width in bits; multiple of STAGE_BITS.
- STAGE_BITS, 4, bits resolved per pipeline stage; multiple of 4.
- NSTAGE (derived, localparam), WIDTH/STAGE_BITS, pipeline depth and latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_a  in  WIDTH  operand A, unsigned/two's complement.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in; add mode only.
- in_sub  in  1  1 = A-B, 0 = A+B+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  result; bit WIDTH is carry-out (sub: 1 = no borrow).
- out_ovf  out  1  signed overflow.

Behaviour:
- Reset, checked on the clock edge with rst=1: all stage valid bits are 0, all data/carry registers are 0. Consequently out_valid=0, out_sum=0, out_ovf=0 and in_ready=1.
- Operand preparation at input:
  - b_eff = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin. In sub mode in_cin is ignored.
- Stage k (k = 0..NSTAGE-1):
  - Adds slice k of A and b_eff to the carry from stage k-1 (c0 for k=0).
  - Uses STAGE_BITS/4 chained 4-bit lookahead groups (cla4_slice).
  - Registers the sum slice, the carry-out and the remaining upper operand slices.
  - Lower sum slices already produced travel alongside in skew registers.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTAGE-1, i.e. NSTAGE register stages. Throughput is 1 beat/cycle.
- Stall: stall = out_valid & ~out_ready.
  - When stall=1, every pipeline register (data and valid) holds.
  - When stall=0, all registers advance.
  - in_ready = ~stall. This is combinational from out_valid/out_ready; it has no dependency on in_valid.
  - Bubbles (in_valid=0 beats) advance as valid=0 entries; no bubble collapsing.
- Handshakes:
  - A beat is accepted only when in_valid & in_ready.
  - out_* stay stable while out_valid=1 and out_ready=0.
- out_ovf = carry into MSB XOR carry out of MSB, computed in the last stage and registered with the sum.
- Carry chain wrap: no wrap. out_sum[WIDTH] is the raw final carry. Example: 0xFFFF+1 gives 0x1_0000.
- Reset mid-operation: all in-flight beats are discarded. No out_valid for them after rst deasserts.
- Reset and stall simultaneous: reset wins.
- NSTAGE=1: degenerates to one registered stage, latency 1, same handshake.
- Width rules:
  - Illegal parameter combinations (WIDTH % STAGE_BITS ≠ 0, STAGE_BITS % 4 ≠ 0) are flagged by an elaboration-time check.
  - No runtime handling of illegal parameters.

Decomposition:
- Shared package cla_pkg holds:
  - localparam CLA_GROUP_BITS = 4.
  - An elaboration-time check function for the parameter legality rules.
- Sub-module cla4_slice: combinational 4-bit lookahead group.
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], cout, plus c3 (carry into bit 3) for overflow detection.
  - Instantiated STAGE_BITS/4 times per stage, chained on cout.
- Top-level owns the pipeline registers, the skew registers and the stall logic.

Test Plan (WIDTH=16, STAGE_BITS=4, latency 4):
- Reset → out_valid=0, out_sum=0x00000, out_ovf=0, in_ready=1, held for 3 cycles with idle inputs.
- Add 0xFFFF+0x0001, cin=0, out_ready=1 → 4 cycles later out_sum=0x1_0000, out_ovf=0. Then add 0x7FFF+0x0000, cin=1 → out_sum=0x0_8000, out_ovf=1.
- Sub 0x0005-0x0007 → out_sum=0x0_FFFE, out_ovf=0. Then sub 0x8000-0x0001 → out_sum=0x1_7FFF, out_ovf=1. Sub with in_cin=1 gives the same results (cin ignored).
- Stream 6 back-to-back random beats, dropping out_ready for 3 cycles when the first result appears → in_ready=0 during the stall, out_sum held stable. All 6 results emerge in order and match the reference model; none lost or duplicated.
- Alternating in_valid 1/0 with out_ready=1 → results appear every other cycle with out_valid pattern 1,0,1,0 aligned 4 cycles after input.
- Load 2 beats, assert rst for 1 cycle while both are in flight → out_valid stays 0 for the next 6 cycles. A new beat afterwards (0x1234+0x1111) → 0x0_2345 after 4 cycles.
